xcore_if_btb: RTL and testbench
===============================

XCORE_IF_BTB -- requirements
Module: xcore_if_btb

Interface
REQ-001 The module SHALL have parameter BTB_ENTRIES, default 8, giving the number of fully associative entries; power of two, 2..32.
REQ-002 The module SHALL have parameter BTB_PTR_W, default 3, giving the entry index width; it SHALL equal log2(BTB_ENTRIES).
REQ-003 i_sys_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 i_sys_rst  input  1  asynchronous, active-low reset.
REQ-005 i_btb_lkp_vld  input  1  lookup request valid (prefetch PC valid).
REQ-006 i_btb_lkp_pc  input  `LEN  lookup PC.
REQ-007 o_btb_hit  output  1  lookup hit, combinational, same cycle.
REQ-008 o_btb_type  output  3  hit entry type: 100 branch, 010 jal, 001 jalr.
REQ-009 o_btb_target  output  `LEN  hit entry target.
REQ-010 i_btb_upd  input  1  update request from the IF branch predictor.
REQ-011 i_btb_upd_pc  input  `LEN  update PC.
REQ-012 i_btb_upd_type  input  3  update type, same one-hot encoding as o_btb_type.
REQ-013 i_btb_upd_target  input  `LEN  update target.
REQ-014 i_btb_upd_valid  input  1  1 = install or refresh; 0 = invalidate matching entry.
REQ-015 i_btb_err  input  1  type mismatch reported by the predictor; forces invalidate of i_btb_upd_pc.
REQ-016 i_btb_flush  input  1  single-cycle pulse requesting full invalidation.
REQ-017 o_btb_busy  output  1  flush in progress.

Function
REQ-018 Tag SHALL be PC[`LEN-1:1]; an entry holds valid, tag, 3-bit type and `LEN-bit target.
REQ-019 Lookup: o_btb_hit SHALL be 1 iff i_btb_lkp_vld=1, o_btb_busy=0, and one valid entry or the pending update buffer matches; on a miss, o_btb_type and o_btb_target SHALL be 0.
REQ-020 Updates SHALL be two-stage: cycle N captures into a pending buffer (pend_vld, pc, type, target, install flag); cycle N+1 writes the array.
REQ-021 Bypass: if the pending buffer is valid and its tag equals the lookup tag, the pending buffer SHALL take priority over the array: its data for an install, a miss for an invalidate.
REQ-022 Install, at write time:
  - a matching valid entry SHALL be overwritten in place;
  - else the lowest-index invalid entry SHALL be used;
  - else the entry at the round-robin pointer SHALL be used, and the pointer SHALL increment modulo BTB_ENTRIES (wrapping from BTB_ENTRIES-1 to 0).
REQ-023 The pointer SHALL change only on an allocation to a full table.
REQ-024 Invalidate (i_btb_upd_valid=0 or i_btb_err=1) SHALL clear the valid bit of the matching entry; with no match, no state changes other than the pending buffer.
REQ-025 If i_btb_err=1 and i_btb_upd_valid=1 in the same cycle, invalidate SHALL win.
REQ-026 Back-to-back updates to the same PC SHALL resolve to a single entry holding the later data.
REQ-027 FSM states SHALL be IDLE and FLUSH:
  - IDLE to FLUSH on i_btb_flush=1;
  - FLUSH clears one entry per cycle, index 0 upward, using a counter;
  - FLUSH to IDLE after entry BTB_ENTRIES-1 is cleared, so the flush takes exactly BTB_ENTRIES cycles.
REQ-028 o_btb_busy SHALL be 1 exactly in FLUSH.
REQ-029 On entry to FLUSH, the pending buffer SHALL be discarded and the round-robin pointer reset to 0.
REQ-030 i_btb_upd SHALL be ignored while busy and in the cycle i_btb_flush is asserted.
REQ-031 i_btb_flush asserted while busy SHALL be ignored; the flush is not restarted.

Reset
REQ-032 On i_sys_rst=0, asynchronously: all valid bits 0, pending buffer invalid, pointer 0, flush counter 0, FSM in IDLE.
REQ-033 Consequently o_btb_hit=0, o_btb_type=0, o_btb_target=0, o_btb_busy=0 during and after reset.
REQ-034 Reset asserted mid-flush or mid-update SHALL abort the operation with no partial state retained.
REQ-035 Tag, type and target storage SHALL need no reset.

Structure
REQ-036 `LEN, `WIDTH, the BTB type encodings (BTB_T_B, BTB_T_JAL, BTB_T_JALR) and the default entry count SHALL live in the shared params include.
REQ-037 One sub-module SHALL be used: xcore_if_btb_alloc, a combinational lowest-invalid-index finder that outputs an index and an any-invalid flag.

Verification
REQ-038 Reset, then lookup PC 0x100 -> o_btb_hit=0, target 0.
REQ-039 Update PC 0x100, type 100, target 0x140, then lookup 0x100 in the next cycle (bypass) and two cycles later (array) -> hit both times, type 100, target 0x140.
REQ-040 Fill 8 distinct PCs 0x0..0x1C, then install 0x200 -> entry 0 replaced, pointer 1; lookup 0x0 misses, 0x200 hits.
REQ-041 With 0x100 installed, assert i_btb_err with i_btb_upd_valid=1 for 0x100 -> the next-cycle lookup misses.
REQ-042 Pulse i_btb_flush with an update in the same cycle -> o_btb_busy high exactly 8 cycles, all lookups miss during and after, update dropped.
REQ-043 Assert reset in the 3rd flush cycle -> busy=0 immediately; after release the table is empty and pointer 0.

Source files
------------

// File: rtl/xcore_if_btb_pkg.sv
// Shared BTB parameters: PC width, one-hot branch type encodings, default size.
// The macros are the common include values; the package mirrors them for typed use.
`ifndef XCORE_IF_PARAMS_SVH
`define XCORE_IF_PARAMS_SVH
`define LEN 32
`define WIDTH 32
`define BTB_T_B 3'b100
`define BTB_T_JAL 3'b010
`define BTB_T_JALR 3'b001
`define BTB_ENTRIES_DEF 8
`endif

package xcore_if_btb_pkg;
  localparam int LEN             = `LEN;
  localparam int TAG_W           = `LEN - 1;
  localparam int BTB_TYPE_W      = 3;
  localparam int BTB_DEF_ENTRIES = `BTB_ENTRIES_DEF;
  localparam logic [2:0] BTB_T_B    = `BTB_T_B;
  localparam logic [2:0] BTB_T_JAL  = `BTB_T_JAL;
  localparam logic [2:0] BTB_T_JALR = `BTB_T_JALR;

  typedef enum logic {ST_IDLE, ST_FLUSH} btb_state_e;
endpackage

// File: rtl/xcore_if_btb_alloc.sv
// Lowest-index invalid entry finder used for BTB allocation.
module xcore_if_btb_alloc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] valid_i,
  output logic [W-1:0] idx_o,
  output logic         any_inv_o
);
  always_comb begin
    idx_o     = '0;
    any_inv_o = 1'b0;
    // Scan downward so the lowest free slot is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        idx_o     = W'(i);
        any_inv_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xcore_if_btb.sv
// Fully associative branch target buffer with a one-deep pending update
// buffer, round-robin replacement and a sequential flush.
module xcore_if_btb
  import xcore_if_btb_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_DEF_ENTRIES,
  parameter int BTB_PTR_W   = 3
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_btb_lkp_vld,
  input  logic [LEN-1:0]        i_btb_lkp_pc,
  output logic                  o_btb_hit,
  output logic [BTB_TYPE_W-1:0] o_btb_type,
  output logic [LEN-1:0]        o_btb_target,
  input  logic                  i_btb_upd,
  input  logic [LEN-1:0]        i_btb_upd_pc,
  input  logic [BTB_TYPE_W-1:0] i_btb_upd_type,
  input  logic [LEN-1:0]        i_btb_upd_target,
  input  logic                  i_btb_upd_valid,
  input  logic                  i_btb_err,
  input  logic                  i_btb_flush,
  output logic                  o_btb_busy
);
  logic [BTB_ENTRIES-1:0]                 valid_q;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]      tag_q;
  logic [BTB_ENTRIES-1:0][BTB_TYPE_W-1:0] type_q;
  logic [BTB_ENTRIES-1:0][LEN-1:0]        tgt_q;

  logic                  pend_vld_q, pend_inst_q;
  logic [TAG_W-1:0]      pend_tag_q;
  logic [BTB_TYPE_W-1:0] pend_type_q;
  logic [LEN-1:0]        pend_tgt_q;

  logic [BTB_PTR_W-1:0]  ptr_q, fcnt_q;
  btb_state_e            state_q;

  logic                  flush_acc, upd_acc, do_wr;
  logic                  wr_hit, any_inv, ins_roll;
  logic [BTB_PTR_W-1:0]  wr_idx, free_idx, ins_idx;
  logic [TAG_W-1:0]      lkp_tag;
  logic                  unused_pc_lsb;

  assign lkp_tag       = i_btb_lkp_pc[LEN-1:1];
  assign unused_pc_lsb = ^{i_btb_lkp_pc[0], i_btb_upd_pc[0]};

  assign o_btb_busy = (state_q == ST_FLUSH);
  assign flush_acc  = (state_q == ST_IDLE) && i_btb_flush;
  assign upd_acc    = (state_q == ST_IDLE) && i_btb_upd && !i_btb_flush;
  assign do_wr      = pend_vld_q && !flush_acc;

  // Lookup: pending buffer shadows the array for the same tag.
  always_comb begin
    o_btb_hit    = 1'b0;
    o_btb_type   = '0;
    o_btb_target = '0;
    if (i_btb_lkp_vld && !o_btb_busy) begin
      if (pend_vld_q && pend_tag_q == lkp_tag) begin
        if (pend_inst_q) begin
          o_btb_hit    = 1'b1;
          o_btb_type   = pend_type_q;
          o_btb_target = pend_tgt_q;
        end
      end else begin
        for (int i = 0; i < BTB_ENTRIES; i++) begin
          if (valid_q[i] && tag_q[i] == lkp_tag) begin
            o_btb_hit    = 1'b1;
            o_btb_type   = o_btb_type | type_q[i];
            o_btb_target = o_btb_target | tgt_q[i];
          end
        end
      end
    end
  end

  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == pend_tag_q) begin
        wr_hit = 1'b1;
        wr_idx = BTB_PTR_W'(i);
      end
    end
  end

  xcore_if_btb_alloc #(.N(BTB_ENTRIES), .W(BTB_PTR_W)) u_alloc (
    .valid_i   (valid_q),
    .idx_o     (free_idx),
    .any_inv_o (any_inv)
  );

  assign ins_roll = !wr_hit && !any_inv;
  assign ins_idx  = wr_hit ? wr_idx : (any_inv ? free_idx : ptr_q);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fcnt_q <= '0;
          if (i_btb_flush) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (fcnt_q == BTB_PTR_W'(BTB_ENTRIES - 1)) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      valid_q    <= '0;
      ptr_q      <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_vld_q <= upd_acc;
      if (state_q == ST_FLUSH) begin
        valid_q[fcnt_q] <= 1'b0;
      end else if (flush_acc) begin
        ptr_q <= '0;
      end else if (do_wr) begin
        if (pend_inst_q) begin
          valid_q[ins_idx] <= 1'b1;
          if (ins_roll) ptr_q <= ptr_q + 1'b1;
        end else if (wr_hit) begin
          valid_q[wr_idx] <= 1'b0;
        end
      end
    end
  end

  // Payload storage is qualified by the valid bits above, so it has no reset.
  always_ff @(posedge i_sys_clk) begin
    if (do_wr && pend_inst_q) begin
      tag_q[ins_idx]  <= pend_tag_q;
      type_q[ins_idx] <= pend_type_q;
      tgt_q[ins_idx]  <= pend_tgt_q;
    end
    if (upd_acc) begin
      pend_tag_q  <= i_btb_upd_pc[LEN-1:1];
      pend_type_q <= i_btb_upd_type;
      pend_tgt_q  <= i_btb_upd_target;
      pend_inst_q <= i_btb_upd_valid && !i_btb_err;
    end
  end
endmodule

// File: tb/tb_xcore_if_btb.sv
// Directed bench for xcore_if_btb: lookup, bypass, replacement, invalidate, flush, reset.
module tb_xcore_if_btb;
  logic        clk, rst_n;
  logic        lkp_vld, hit, upd, upd_valid, err, flush, busy;
  logic [31:0] lkp_pc, tgt, upd_pc, upd_tgt;
  logic [2:0]  typ, upd_type;
  int          nvec, nerr;

  xcore_if_btb dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n),
    .i_btb_lkp_vld(lkp_vld), .i_btb_lkp_pc(lkp_pc),
    .o_btb_hit(hit), .o_btb_type(typ), .o_btb_target(tgt),
    .i_btb_upd(upd), .i_btb_upd_pc(upd_pc), .i_btb_upd_type(upd_type),
    .i_btb_upd_target(upd_tgt), .i_btb_upd_valid(upd_valid),
    .i_btb_err(err), .i_btb_flush(flush), .o_btb_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic do_upd(input logic [31:0] pc, input logic [2:0] ty,
                        input logic [31:0] tg, input logic v, input logic e);
    upd = 1'b1; upd_pc = pc; upd_type = ty; upd_tgt = tg; upd_valid = v; err = e;
    @(posedge clk); #1;
    upd = 1'b0; upd_valid = 1'b1; err = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic lkp(input logic [31:0] pc);
    lkp_vld = 1'b1; lkp_pc = pc; #1;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++)
      do_upd(32'(i * 4), 3'b010, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lkp_vld = 1'b1; lkp_pc = 32'h100;
    tick(2);
    nvec++;
    if (hit !== 1'b0 || typ !== 3'b000 || tgt !== 32'h0 || busy !== 1'b0) begin
      nerr++; $display("FAIL reset_hold hit=%b type=%b tgt=%h busy=%b want 0 000 0 0", hit, typ, tgt, busy);
    end
    rst_n = 1'b1; tick(1); lkp(32'h100);
    nvec++;
    if (hit !== 1'b0 || typ !== 3'b000 || tgt !== 32'h0 || busy !== 1'b0) begin
      nerr++; $display("FAIL reset_lookup hit=%b type=%b tgt=%h busy=%b want 0 000 0 0", hit, typ, tgt, busy);
    end
  endtask

  task automatic test_install_bypass();
    do_upd(32'h100, 3'b100, 32'h140, 1'b1, 1'b0);
    lkp(32'h100);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b100 || tgt !== 32'h140) begin
      nerr++; $display("FAIL bypass_hit hit=%b type=%b tgt=%h want 1 100 140", hit, typ, tgt);
    end
    tick(1); lkp(32'h100);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b100 || tgt !== 32'h140) begin
      nerr++; $display("FAIL array_hit hit=%b type=%b tgt=%h want 1 100 140", hit, typ, tgt);
    end
    lkp_vld = 1'b0; #1;
    nvec++;
    if (hit !== 1'b0 || tgt !== 32'h0) begin
      nerr++; $display("FAIL lkp_vld_low hit=%b tgt=%h want 0 0", hit, tgt);
    end
  endtask

  task automatic test_invalidate();
    do_upd(32'h100, 3'b100, 32'h0, 1'b0, 1'b0);
    lkp(32'h100);
    nvec++;
    if (hit !== 1'b0 || tgt !== 32'h0) begin
      nerr++; $display("FAIL inval_bypass hit=%b tgt=%h want 0 0", hit, tgt);
    end
    tick(1); lkp(32'h100);
    nvec++;
    if (hit !== 1'b0) begin
      nerr++; $display("FAIL inval_array hit=%b want 0", hit);
    end
  endtask

  task automatic test_err();
    do_upd(32'h100, 3'b100, 32'h140, 1'b1, 1'b0);
    tick(1);
    do_upd(32'h100, 3'b100, 32'h140, 1'b1, 1'b1);
    lkp(32'h100);
    nvec++;
    if (hit !== 1'b0) begin
      nerr++; $display("FAIL err_bypass hit=%b want 0", hit);
    end
    tick(1); lkp(32'h100);
    nvec++;
    if (hit !== 1'b0) begin
      nerr++; $display("FAIL err_array hit=%b want 0", hit);
    end
  endtask

  task automatic test_back_to_back();
    do_upd(32'h180, 3'b001, 32'h11, 1'b1, 1'b0);
    do_upd(32'h180, 3'b010, 32'h22, 1'b1, 1'b0);
    tick(2); lkp(32'h180);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b010 || tgt !== 32'h22) begin
      nerr++; $display("FAIL b2b_same_pc hit=%b type=%b tgt=%h want 1 010 22", hit, typ, tgt);
    end
  endtask

  task automatic test_replace();
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    fill8();
    do_upd(32'h200, 3'b001, 32'h2222, 1'b1, 1'b0);
    tick(1);
    lkp(32'h0);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL evict_e0 hit=%b want 0", hit); end
    lkp(32'h200);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b001 || tgt !== 32'h2222) begin
      nerr++; $display("FAIL new_200 hit=%b type=%b tgt=%h want 1 001 2222", hit, typ, tgt);
    end
    lkp(32'h4);
    nvec++;
    if (hit !== 1'b1 || tgt !== 32'h1004) begin
      nerr++; $display("FAIL keep_4 hit=%b tgt=%h want 1 1004", hit, tgt);
    end
    // Refreshing a resident PC must not evict anything.
    do_upd(32'h8, 3'b100, 32'h8888, 1'b1, 1'b0);
    do_upd(32'h300, 3'b100, 32'h3333, 1'b1, 1'b0);
    tick(1);
    lkp(32'h4);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL ptr1_evict_4 hit=%b want 0", hit); end
    lkp(32'h8);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b100 || tgt !== 32'h8888) begin
      nerr++; $display("FAIL refresh_8 hit=%b type=%b tgt=%h want 1 100 8888", hit, typ, tgt);
    end
    lkp(32'hC);
    nvec++;
    if (hit !== 1'b1 || tgt !== 32'h100C) begin
      nerr++; $display("FAIL keep_c hit=%b tgt=%h want 1 100c", hit, tgt);
    end
    lkp(32'h300);
    nvec++;
    if (hit !== 1'b1 || tgt !== 32'h3333) begin
      nerr++; $display("FAIL new_300 hit=%b tgt=%h want 1 3333", hit, tgt);
    end
  endtask

  task automatic test_flush();
    int nbusy;
    nbusy = 0;
    lkp_vld = 1'b1; lkp_pc = 32'h200;
    flush = 1'b1;
    upd = 1'b1; upd_pc = 32'h400; upd_type = 3'b100; upd_tgt = 32'h4444; upd_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; upd = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (busy === 1'b1) nbusy++;
      nvec++;
      if (hit !== 1'b0) begin nerr++; $display("FAIL flush_lookup cyc=%0d hit=%b want 0", c, hit); end
      flush = (c == 3);
      upd = (c == 2); upd_pc = 32'h500;
      @(posedge clk); #1;
    end
    flush = 1'b0; upd = 1'b0;
    nvec++;
    if (nbusy != 8) begin nerr++; $display("FAIL busy_cycles got=%0d want 8", nbusy); end
    lkp(32'h200);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL post_flush_200 hit=%b want 0", hit); end
    lkp(32'h400);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL flush_upd_drop hit=%b want 0", hit); end
    lkp(32'h500);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL busy_upd_drop hit=%b want 0", hit); end
    lkp(32'h1C);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL post_flush_1c hit=%b want 0", hit); end
  endtask

  task automatic test_reset_mid_flush();
    fill8();
    do_upd(32'h200, 3'b100, 32'h2, 1'b1, 1'b0);
    tick(1);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    tick(2);
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL busy_before_rst busy=%b want 1", busy); end
    rst_n = 1'b0; #1;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL busy_async_rst busy=%b want 0", busy); end
    tick(1); rst_n = 1'b1; tick(1);
    lkp(32'h1C);
    nvec++;
    if (hit !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL rst_empty hit=%b busy=%b want 0 0", hit, busy);
    end
    fill8();
    do_upd(32'h700, 3'b001, 32'h7777, 1'b1, 1'b0);
    tick(1);
    lkp(32'h0);
    nvec++;
    if (hit !== 1'b0) begin nerr++; $display("FAIL rst_ptr0_evict hit=%b want 0", hit); end
    lkp(32'h4);
    nvec++;
    if (hit !== 1'b1 || tgt !== 32'h1004) begin
      nerr++; $display("FAIL rst_keep_4 hit=%b tgt=%h want 1 1004", hit, tgt);
    end
    lkp(32'h700);
    nvec++;
    if (hit !== 1'b1 || typ !== 3'b001 || tgt !== 32'h7777) begin
      nerr++; $display("FAIL rst_new_700 hit=%b type=%b tgt=%h want 1 001 7777", hit, typ, tgt);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0; lkp_vld = 1'b0; lkp_pc = '0;
    upd = 1'b0; upd_pc = '0; upd_type = '0; upd_tgt = '0; upd_valid = 1'b1;
    err = 1'b0; flush = 1'b0;
    #1;
    test_reset();
    test_install_bypass();
    test_invalidate();
    test_err();
    test_back_to_back();
    test_replace();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
